// File: rtl/apu_frame_counter_gen2.sv
// APU frame sequencer ($4017): counts CPU cycles, emits quarter/half-frame strobes,
// owns the frame IRQ flag and the parity-dependent delayed sequence reset after a write.
module apu_frame_counter_gen2 #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned STEP1 = 7457,
    parameter int unsigned STEP2 = 14913,
    parameter int unsigned STEP3 = 22371,
    parameter int unsigned STEP4 = 29829,
    parameter int unsigned STEP5 = 37281
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_clk,
    input  logic       wren,
    input  logic [1:0] from_cpu,
    input  logic       irq_ack,
    output logic       e_pulse,
    output logic       l_pulse,
    output logic       frame_irq
);

    localparam logic [CNT_W-1:0] S1  = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2  = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3  = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4  = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S4M = CNT_W'(STEP4 - 1);
    localparam logic [CNT_W-1:0] S5  = CNT_W'(STEP5);

    typedef enum logic {RUN, PEND} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode, mode_nxt;
    logic             inhibit, inhibit_nxt;
    logic             parity, parity_nxt;
    logic [2:0]       delay, delay_nxt;
    logic             e_nxt, l_nxt, irq_nxt;
    logic             irq_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            mode      <= 1'b0;
            inhibit   <= 1'b0;
            parity    <= 1'b0;
            delay     <= '0;
            e_pulse   <= 1'b0;
            l_pulse   <= 1'b0;
            frame_irq <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mode      <= mode_nxt;
            inhibit   <= inhibit_nxt;
            parity    <= parity_nxt;
            delay     <= delay_nxt;
            e_pulse   <= e_nxt;
            l_pulse   <= l_nxt;
            frame_irq <= irq_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mode_nxt    = mode;
        inhibit_nxt = inhibit;
        parity_nxt  = parity;
        delay_nxt   = delay;
        e_nxt       = 1'b0;
        l_nxt       = 1'b0;
        irq_set     = 1'b0;

        if (cpu_clk) begin
            parity_nxt = ~parity;
            cnt_nxt    = cnt + CNT_W'(1);
            if (cnt == S1 || cnt == S3) begin
                e_nxt = 1'b1;
            end
            if (cnt == S2) begin
                e_nxt = 1'b1;
                l_nxt = 1'b1;
            end
            if ((!mode && cnt == S4) || (mode && cnt == S5)) begin
                e_nxt   = 1'b1;
                l_nxt   = 1'b1;
                cnt_nxt = '0;
            end
            irq_set = !mode && !inhibit && (cnt == S4M || cnt == S4);

            // Delayed sequence reset overrides the step wrap/increment on its final cycle.
            if (state == PEND) begin
                delay_nxt = delay - 3'd1;
                if (delay == 3'd1) begin
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                    if (mode) begin
                        e_nxt = 1'b1;
                        l_nxt = 1'b1;
                    end
                end
            end
        end

        // A write always restarts the delay, even on the final pending cycle.
        if (wren) begin
            mode_nxt    = from_cpu[1];
            inhibit_nxt = from_cpu[0];
            delay_nxt   = parity ? 3'd4 : 3'd3;
            state_nxt   = PEND;
        end

        if (wren && from_cpu[0]) begin
            irq_nxt = 1'b0;
        end else if (irq_set) begin
            irq_nxt = 1'b1;
        end else if (irq_ack) begin
            irq_nxt = 1'b0;
        end else begin
            irq_nxt = frame_irq;
        end
    end

endmodule

// File: tb/tb_apu_frame_counter_gen2.sv
// Directed bench for apu_frame_counter_gen2 using shortened step values (7/14/22/29/37);
// each CPU cycle is one cpu_clk clk followed by one idle clk.
module tb_apu_frame_counter_gen2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_clk = 1'b0;
    logic       wren = 1'b0;
    logic [1:0] from_cpu = 2'b00;
    logic       irq_ack = 1'b0;
    logic       e_pulse, l_pulse, frame_irq;

    int checks = 0;
    int errors = 0;
    int e_at[$];
    int l_at[$];
    int exp_q[$];
    int irq_rise;
    int irq_first;
    int idle_bad;

    apu_frame_counter_gen2 #(
        .CNT_W(8), .STEP1(7), .STEP2(14), .STEP3(22), .STEP4(29), .STEP5(37)
    ) dut (
        .clk(clk), .rst(rst), .cpu_clk(cpu_clk), .wren(wren), .from_cpu(from_cpu),
        .irq_ack(irq_ack), .e_pulse(e_pulse), .l_pulse(l_pulse), .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    task automatic op(input logic w, input logic [1:0] d, input logic a, input logic r);
        wren = w; from_cpu = d; irq_ack = a; rst = r;
        @(posedge clk); #1;
        wren = 1'b0; irq_ack = 1'b0; rst = 1'b0;
    endtask

    // Steps n CPU cycles, logging which cycle index (1-based) produced each strobe.
    task automatic run(input int n);
        logic irq_prev;
        e_at.delete(); l_at.delete();
        irq_rise = 0; irq_first = 0; idle_bad = 0;
        irq_prev = frame_irq;
        for (int i = 1; i <= n; i++) begin
            cpu_clk = 1'b1;
            @(posedge clk); #1;
            cpu_clk = 1'b0;
            if (e_pulse) e_at.push_back(i);
            if (l_pulse) l_at.push_back(i);
            if (frame_irq && !irq_prev) begin
                irq_rise++;
                if (irq_first == 0) irq_first = i;
            end
            irq_prev = frame_irq;
            @(posedge clk); #1;
            if (e_pulse || l_pulse) idle_bad++;
        end
    endtask

    initial begin
        // Reset state
        op(1'b0, 2'b00, 1'b0, 1'b1);
        op(1'b0, 2'b00, 1'b0, 1'b1);
        check("rst_e", int'(e_pulse), 0);
        check("rst_l", int'(l_pulse), 0);
        check("rst_irq", int'(frame_irq), 0);

        // Mode 0, two frames of period 30
        run(60);
        exp_q = '{8, 15, 23, 30, 38, 45, 53, 60};
        check_list("m0_e", e_at, exp_q);
        exp_q = '{15, 30, 45, 60};
        check_list("m0_l", l_at, exp_q);
        check("m0_irq_first", irq_first, 29);
        check("m0_irq_rises", irq_rise, 1);
        check("m0_irq_level", int'(frame_irq), 1);
        check("m0_idle", idle_bad, 0);

        // irq_ack clears the flag
        op(1'b0, 2'b00, 1'b1, 1'b0);
        check("ack_clear", int'(frame_irq), 0);

        // irq_ack coinciding with the set cycle (cnt == STEP4-1): set wins
        run(28);
        check("pre_set_irq", int'(frame_irq), 0);
        cpu_clk = 1'b1; irq_ack = 1'b1;
        @(posedge clk); #1;
        cpu_clk = 1'b0; irq_ack = 1'b0;
        check("ack_vs_set", int'(frame_irq), 1);
        @(posedge clk); #1;
        run(1);
        check("wrap_e", int'(e_at.size()), 1);
        check("wrap_l", int'(l_at.size()), 1);

        // Write inhibit on even parity: irq cleared, reset after 3 cycles, no irq after
        op(1'b1, 2'b01, 1'b0, 1'b0);
        check("inh_clear", int'(frame_irq), 0);
        run(63);
        exp_q = '{11, 18, 26, 33, 41, 48, 56, 63};
        check_list("inh_e", e_at, exp_q);
        exp_q = '{18, 33, 48, 63};
        check_list("inh_l", l_at, exp_q);
        check("inh_irq_rises", irq_rise, 0);

        // Mode 1 write on odd parity: reset with pulses after 4 cycles, period 38
        op(1'b1, 2'b10, 1'b0, 1'b0);
        run(80);
        exp_q = '{4, 12, 19, 27, 42, 50, 57, 65, 80};
        check_list("m1_e", e_at, exp_q);
        exp_q = '{4, 19, 42, 57, 80};
        check_list("m1_l", l_at, exp_q);
        check("m1_irq_rises", irq_rise, 0);
        check("m1_idle", idle_bad, 0);

        // Mode 1 write on even parity: reset after 3 cycles
        run(1);
        op(1'b1, 2'b10, 1'b0, 1'b0);
        run(11);
        exp_q = '{3, 11};
        check_list("even_e", e_at, exp_q);
        exp_q = '{3};
        check_list("even_l", l_at, exp_q);

        // Second write restarts the delay: one reset only, no pulse in mode 0
        op(1'b1, 2'b10, 1'b0, 1'b0);
        run(2);
        check("rw_gap_e", int'(e_at.size()), 0);
        op(1'b1, 2'b00, 1'b0, 1'b0);
        run(19);
        exp_q = '{12, 19};
        check_list("rw_e", e_at, exp_q);
        exp_q = '{19};
        check_list("rw_l", l_at, exp_q);

        // Reset while pending: no delayed pulse, sequence restarts in mode 0
        op(1'b1, 2'b10, 1'b0, 1'b0);
        run(1);
        op(1'b0, 2'b00, 1'b0, 1'b1);
        check("prst_e", int'(e_pulse), 0);
        check("prst_l", int'(l_pulse), 0);
        check("prst_irq", int'(frame_irq), 0);
        run(30);
        exp_q = '{8, 15, 23, 30};
        check_list("prst_e_at", e_at, exp_q);
        exp_q = '{15, 30};
        check_list("prst_l_at", l_at, exp_q);
        check("prst_irq_first", irq_first, 29);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
